spi_req_arbiter: RTL

- Shares one SPI master transaction port (wr/addr/din in; dout/done/err out) between N independent requesters.
- Arbitrates round-robin, runs exactly one transaction at a time, and returns read data and error status to the winner.
- Includes a watchdog that terminates a transaction if done never arrives.
- Sits between the requesters (CPU bus bridge, init sequencer) and the SPI master/slave/memory subsystem; adds an m_start strobe for the master.

---
 rtl/spi_arb_pkg.sv | 11 +
 rtl/spi_req_arbiter_if.sv | 31 +++
 rtl/spi_rr_pick.sv | 27 ++
 rtl/spi_req_arbiter.sv | 130 +++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared state encoding, default widths and helpers for the SPI request arbiter.
package spi_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
    localparam int DEF_N = 2;
    localparam int DEF_AW = 8;
    localparam int DEF_DW = 8;
    localparam int DEF_TIMEOUT = 1024;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/spi_req_arbiter_if.sv
// spi_req_arbiter_if: requester-side and SPI-master-side signals of the arbiter.
interface spi_req_arbiter_if #(
    parameter int N = 2,
    parameter int AW = 8,
    parameter int DW = 8
);
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_wr;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_din;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            rsp_err;
    logic            m_start;
    logic            m_wr;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_din;
    logic [DW-1:0]   m_dout;
    logic            m_done;
    logic            m_err;
    logic            busy;
    modport slave (
        input  req_valid, req_wr, req_addr, req_din, m_dout, m_done, m_err,
        output req_ready, rsp_valid, rsp_data, rsp_err, m_start, m_wr, m_addr, m_din, busy
    );
    modport master (
        output req_valid, req_wr, req_addr, req_din, m_dout, m_done, m_err,
        input  req_ready, rsp_valid, rsp_data, rsp_err, m_start, m_wr, m_addr, m_din, busy
    );
endinterface

// File: rtl/spi_rr_pick.sv
// spi_rr_pick: combinational rotate-priority picker; first valid index at or above ptr, wrapping at N.
module spi_rr_pick
    import spi_arb_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int PW = idx_w(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] ptr,
    output logic          found,
    output logic [PW-1:0] idx
);
    logic [PW-1:0] cand;
    always_comb begin
        found = 1'b0;
        idx = '0;
        cand = '0;
        // Scan farthest offset first so the nearest valid index wins last.
        for (int k = N - 1; k >= 0; k--) begin
            cand = PW'((int'(ptr) + k) % N);
            if (valid[cand]) begin
                found = 1'b1;
                idx = cand;
            end
        end
    end
endmodule

// File: rtl/spi_req_arbiter.sv
// spi_req_arbiter: round-robin share of one SPI master port among N requesters,
// one transaction at a time, with a watchdog that forces an error if m_done never comes.
module spi_req_arbiter
    import spi_arb_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input logic clk,
    input logic rst,
    spi_req_arbiter_if.slave bus
);
    localparam int PW = idx_w(N);
    localparam int TW = $clog2(TIMEOUT);

    arb_state_t    state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d, grant_q, grant_d, pick;
    logic          found;
    logic          wr_q, wr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] din_q, din_d, rsp_data_q, rsp_data_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [N-1:0]  ready_q, ready_d, rsp_valid_q, rsp_valid_d;
    logic          rsp_err_q, rsp_err_d, m_start_q, m_start_d, busy_q, busy_d;
    logic          expired;

    spi_rr_pick #(.N(N), .PW(PW)) u_pick (
        .valid(bus.req_valid),
        .ptr  (ptr_q),
        .found(found),
        .idx  (pick)
    );

    assign expired = timer_q == TW'(TIMEOUT - 1);

    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        grant_d = grant_q;
        wr_d = wr_q;
        addr_d = addr_q;
        din_d = din_q;
        timer_d = timer_q;
        ready_d = '0;
        rsp_valid_d = '0;
        rsp_data_d = rsp_data_q;
        rsp_err_d = rsp_err_q;
        m_start_d = 1'b0;
        case (state_q)
            IDLE: if (found) begin
                grant_d = pick;
                wr_d = bus.req_wr[pick];
                addr_d = bus.req_addr[pick*AW +: AW];
                din_d = bus.req_din[pick*DW +: DW];
                ready_d[pick] = 1'b1;
                state_d = ISSUE;
            end
            ISSUE: begin
                m_start_d = 1'b1;
                timer_d = '0;
                state_d = WAIT;
            end
            // While the start strobe is still visible the master cannot have finished, so done is ignored.
            WAIT: if (!m_start_q) begin
                if (bus.m_done) begin
                    rsp_data_d = wr_q ? '0 : bus.m_dout;
                    rsp_err_d = bus.m_err;
                    rsp_valid_d[grant_q] = 1'b1;
                    state_d = RESP;
                end else if (expired) begin
                    rsp_data_d = '0;
                    rsp_err_d = 1'b1;
                    rsp_valid_d[grant_q] = 1'b1;
                    state_d = RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RESP: begin
                ptr_d = (grant_q == PW'(N - 1)) ? '0 : grant_q + 1'b1;
                state_d = IDLE;
            end
        endcase
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q <= '0;
            grant_q <= '0;
            wr_q <= 1'b0;
            addr_q <= '0;
            din_q <= '0;
            timer_q <= '0;
            ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_data_q <= '0;
            rsp_err_q <= 1'b0;
            m_start_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            grant_q <= grant_d;
            wr_q <= wr_d;
            addr_q <= addr_d;
            din_q <= din_d;
            timer_q <= timer_d;
            ready_q <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q <= rsp_err_d;
            m_start_q <= m_start_d;
            busy_q <= busy_d;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data = rsp_data_q;
    assign bus.rsp_err = rsp_err_q;
    assign bus.m_start = m_start_q;
    assign bus.m_wr = wr_q;
    assign bus.m_addr = addr_q;
    assign bus.m_din = din_q;
    assign bus.busy = busy_q;
endmodule
